player_motion_controller: RTL
=============================

Name: player_motion_controller

Overview:
- Per-frame position sequencer for the player sprite's rectangle object; drives its topLeftX/topLeftY.
- Runs an FSM for walking, jumping with fixed-point gravity, and a hit/respawn freeze.
- Sits between the keyboard/collision logic and the sprite's rectangle/bitmap objects. All updates happen once per startOfFrame pulse.

Parameters:
- INITIAL_X, 280, spawn/respawn topLeftX in pixels.
- GROUND_Y, 400, topLeftY in pixels when standing.
- X_SPEED, 2, horizontal pixels per frame.
- X_MIN, 0, minimum topLeftX.
- X_MAX, 608, maximum topLeftX (640 minus the 32-pixel object width).
- JUMP_SPEED, -512, initial vertical speed in 1/64-pixel units per frame (negative is up).
- GRAVITY, 16, vertical speed increment per frame in 1/64-pixel units.
- HIT_FRAMES, 60, number of frames to freeze after a hit.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- leftKey  in  1  level, move left
- rightKey  in  1  level, move right
- jumpKey  in  1  level, start jump
- collision  in  1  pulse/level from collision detector
- topLeftX  out  11  sprite X in pixels
- topLeftY  out  11  sprite Y in pixels
- jumping  out  1  high while AIRBORNE
- hitActive  out  1  high while HIT
- landedPulse  out  1  one-cycle pulse on landing

Behaviour:
- Clock and reset: single clock clk. resetN is asynchronous and active-low.
- Reset values:
  - state = GROUNDED, xPos = INITIAL_X, yFix = GROUND_Y*64, ySpeed = 0, hitCnt = 0, collisionLatch = 0.
  - topLeftX = INITIAL_X, topLeftY = GROUND_Y, jumping = 0, hitActive = 0, landedPulse = 0.
  - Reset mid-operation aborts any jump or hit immediately.
- Internal widths: yFix and ySpeed are signed 32-bit (int); xPos is signed 32-bit. topLeftY = yFix >>> 6, truncated to 11 bits. topLeftX = xPos[10:0].
- collisionLatch:
  - Set on any cycle with collision=1 while state != HIT.
  - Cleared in the cycle it is consumed, i.e. on startOfFrame.
  - If collision and startOfFrame coincide, that collision counts for the current frame.
  - Collisions during HIT are ignored and not latched.
- Updates happen only in cycles with startOfFrame=1. New outputs are visible the following cycle (latency 1). Outputs hold between pulses.
- Horizontal motion, applied in GROUNDED and AIRBORNE:
  - leftKey only: xPos -= X_SPEED.
  - rightKey only: xPos += X_SPEED.
  - Both keys or neither: no change.
  - Result is clamped to [X_MIN, X_MAX] using signed compare, so no wrap below 0.
- GROUNDED state:
  - If collisionLatch (including same-cycle collision): go to HIT, hitCnt = 0, no motion this frame.
  - Else if jumpKey: go to AIRBORNE, ySpeed = JUMP_SPEED, yFix unchanged this frame. X moves normally.
  - Else: X-only update.
- AIRBORNE state:
  - Collision has priority over landing: it goes to HIT with position frozen at its pre-frame value.
  - Otherwise: newY = yFix + ySpeed; ySpeed += GRAVITY.
  - If newY >= GROUND_Y*64: yFix = GROUND_Y*64, ySpeed = 0, go to GROUNDED, landedPulse = 1 for exactly one cycle.
  - jumpKey is ignored while AIRBORNE (no double jump). Holding jumpKey through a landing starts a new jump on the next frame, not the landing frame.
- HIT state:
  - X and Y are frozen; hitActive = 1; hitCnt increments each frame.
  - When hitCnt == HIT_FRAMES-1 on a frame pulse: xPos = INITIAL_X, yFix = GROUND_Y*64, ySpeed = 0, go to GROUNDED.
- jumping = (state == AIRBORNE), registered. hitActive = (state == HIT), registered.

Test Plan:
- Reset, then 10 frames with rightKey held -> topLeftX = 300, topLeftY = 400, jumping = 0.
- xPos = 1, then 1 frame with leftKey -> topLeftX = 0. Then 5 frames with rightKey from 606 -> topLeftX = 608, never 610. Both keys held -> topLeftX unchanged.
- jumpKey for 1 frame from ground -> jumping = 1. topLeftY = 392 after frame 2 and minimum 268 after frames 33/34. Landing on frame 66 (65 airborne updates): topLeftY = 400, landedPulse is high one cycle, jumping = 0.
- jumpKey held through a landing -> the next jump starts exactly 1 frame after the landing frame. Pressing jump mid-air -> no speed change.
- collision pulse mid-air at topLeftY = 300 -> hitActive = 1 next frame, position frozen for 60 frames, then topLeftX = 280, topLeftY = 400, state GROUNDED. Collisions during HIT have no effect.
- collision in the same cycle as startOfFrame -> HIT entered that frame. Assert resetN mid-jump -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/player_motion_controller.sv
// Per-frame position sequencer for the player sprite. It handles walking, jumping
// under fixed-point gravity, and the freeze-and-respawn that follows a hit.
module player_motion_controller #(
  parameter int INITIAL_X  = 280,
  parameter int GROUND_Y   = 400,
  parameter int X_SPEED    = 2,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 608,
  parameter int JUMP_SPEED = -512,
  parameter int GRAVITY    = 16,
  parameter int HIT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        leftKey,
  input  logic        rightKey,
  input  logic        jumpKey,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        jumping,
  output logic        hitActive,
  output logic        landedPulse
);

  typedef enum logic [1:0] {GROUNDED, AIRBORNE, HIT} state_t;

  // Vertical position is kept in 1/64-pixel units so that gravity can be fractional.
  localparam int GROUND_FIX = GROUND_Y * 64;

  state_t state, state_nx;
  int     x_pos, x_nx, x_walk;
  int     y_fix, y_nx, y_air;
  int     y_speed, speed_nx;
  int     hit_cnt, hit_nx;
  logic   collision_latch;
  logic   hit_req;
  logic   landed_nx;

  // A collision in the same cycle as the frame pulse still counts for that frame.
  assign hit_req = collision_latch | collision;
  assign y_air   = y_fix + y_speed;

  // Horizontal step, clamped with a signed compare so that x never wraps below zero.
  always_comb begin
    x_walk = x_pos;
    if (leftKey && !rightKey)      x_walk = x_pos - X_SPEED;
    else if (rightKey && !leftKey) x_walk = x_pos + X_SPEED;
    if (x_walk < X_MIN)            x_walk = X_MIN;
    else if (x_walk > X_MAX)       x_walk = X_MAX;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
    state_nx  = state;
    x_nx      = x_pos;
    y_nx      = y_fix;
    speed_nx  = y_speed;
    hit_nx    = hit_cnt;
    landed_nx = 1'b0;
    case (state)
      GROUNDED: begin
        if (hit_req) begin
          state_nx = HIT;
          hit_nx   = 0;
        end else begin
          x_nx = x_walk;
          if (jumpKey) begin
            state_nx = AIRBORNE;
            speed_nx = JUMP_SPEED;
          end
        end
      end
      AIRBORNE: begin
        if (hit_req) begin
          state_nx = HIT;
          hit_nx   = 0;
        end else begin
          x_nx = x_walk;
          if (y_air >= GROUND_FIX) begin
            state_nx  = GROUNDED;
            y_nx      = GROUND_FIX;
            speed_nx  = 0;
            landed_nx = 1'b1;
          end else begin
            y_nx     = y_air;
            speed_nx = y_speed + GRAVITY;
          end
        end
      end
      HIT: begin
        if (hit_cnt == HIT_FRAMES - 1) begin
          state_nx = GROUNDED;
          x_nx     = INITIAL_X;
          y_nx     = GROUND_FIX;
          speed_nx = 0;
        end else begin
          hit_nx = hit_cnt + 1;
        end
      end
      default: state_nx = GROUNDED;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= GROUNDED;
      x_pos           <= INITIAL_X;
      y_fix           <= GROUND_FIX;
      y_speed         <= 0;
      hit_cnt         <= 0;
      collision_latch <= 1'b0;
      topLeftX        <= 11'(INITIAL_X);
      topLeftY        <= 11'(GROUND_Y);
      jumping         <= 1'b0;
      hitActive       <= 1'b0;
      landedPulse     <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignments, so every register samples the pre-edge values.
      landedPulse <= 1'b0;
      if (startOfFrame) begin
        state           <= state_nx;
        x_pos           <= x_nx;
        y_fix           <= y_nx;
        y_speed         <= speed_nx;
        hit_cnt         <= hit_nx;
        collision_latch <= 1'b0;
        topLeftX        <= 11'(x_nx);
        topLeftY        <= 11'(y_nx >>> 6);
        jumping         <= (state_nx == AIRBORNE);
        hitActive       <= (state_nx == HIT);
        landedPulse     <= landed_nx;
      end else if (collision && state != HIT) begin
        collision_latch <= 1'b1;
      end
    end
  end

endmodule
